md5_rd_arbiter: RTL

//  Shares one AXI4 read master (ar*/r* _m channels) between NUM_REQ read

---
 rtl/md5_rd_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/md5_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master between NUM_REQ requesters,
// with per-requester outstanding-burst credits and RID-based R steering.
module md5_rd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 512,
    parameter int MAX_OUTST = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [64*NUM_REQ-1:0] req_araddr,
    input  logic [8*NUM_REQ-1:0]  req_arlen,
    input  logic [NUM_REQ-1:0]    req_arvalid,
    output logic [NUM_REQ-1:0]    req_arready,
    output logic [DATA_W-1:0]     req_rdata,
    output logic                  req_rlast,
    output logic [NUM_REQ-1:0]    req_rvalid,
    input  logic [NUM_REQ-1:0]    req_rready,
    output logic [15:0]           arid_m,
    output logic [63:0]           araddr_m,
    output logic [7:0]            arlen_m,
    output logic [2:0]            arsize_m,
    output logic                  arvalid_m,
    input  logic                  arready_m,
    input  logic [15:0]           rid_m,
    input  logic [DATA_W-1:0]     rdata_m,
    input  logic                  rlast_m,
    input  logic                  rvalid_m,
    output logic                  rready_m,
    output logic                  rid_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_OUTST + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       rr_ptr;
    logic [CW-1:0]       outst [NUM_REQ];
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  inc_vec;
    logic [NUM_REQ-1:0]  dec_vec;
    logic                found;
    logic                grant;
    logic [IW-1:0]       sel;
    logic [IW:0]         scan_sum;
    logic [IW-1:0]       scan_idx;
    logic [63:0]         sel_addr;
    logic [7:0]          sel_len;
    logic                rid_ok;

    // Scan from rr_ptr upward with wrap; first eligible requester wins.
    always_comb begin
        eligible = '0;
        found    = 1'b0;
        sel      = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = req_arvalid[i] && (outst[i] < CW'(MAX_OUTST));
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (scan_sum >= (IW+1)'(NUM_REQ))
                scan_sum = scan_sum - (IW+1)'(NUM_REQ);
            scan_idx = scan_sum[IW-1:0];
            if (!found && eligible[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        inc_vec  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IW'(i)) begin
                sel_addr   = req_araddr[64*i +: 64];
                sel_len    = req_arlen[8*i +: 8];
                inc_vec[i] = grant;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                grant = found;
                if (found)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                if (arready_m)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign arvalid_m = (state == ISSUE);
    assign arsize_m  = 3'b110;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            req_arready <= '0;
            arid_m      <= '0;
            araddr_m    <= '0;
            arlen_m     <= '0;
            rid_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            req_arready <= inc_vec;
            if (grant) begin
                arid_m   <= 16'(sel);
                araddr_m <= sel_addr;
                arlen_m  <= sel_len;
                rr_ptr   <= (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);
            end
            if (rvalid_m && !rid_ok)
                rid_err <= 1'b1;
        end
    end

    // Out-of-range RIDs are accepted and discarded so the shell never stalls.
    always_comb begin
        req_rvalid = '0;
        rready_m   = 1'b1;
        rid_ok     = 1'b0;
        dec_vec    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rid_m == 16'(i)) begin
                rid_ok        = 1'b1;
                req_rvalid[i] = rvalid_m;
                rready_m      = req_rready[i];
                dec_vec[i]    = rvalid_m && req_rready[i] && rlast_m;
            end
        end
    end

    assign req_rdata = rdata_m;
    assign req_rlast = rlast_m;

    // Decrement saturates so stale beats arriving after a reset cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++)
                outst[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    outst[i] <= outst[i] + CW'(1);
                else if (dec_vec[i] && !inc_vec[i] && (outst[i] != '0))
                    outst[i] <= outst[i] - CW'(1);
            end
        end
    end

endmodule
